// File: rtl/adc_avg_pkg.sv
// Shared widths, accumulator sizing and the result payload for the adc_avg averager.
// The out_min/out_max fields exist only when ADC_AVG_MINMAX_EN is defined.
package adc_avg_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned CHAN_W = 4;

  // Wide enough to hold a full window of maximum-value samples without wrapping
  function automatic int unsigned acc_w(input int unsigned log2_avg);
    return DATA_W + log2_avg;
  endfunction

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHAN_W-1:0] channel;
`ifdef ADC_AVG_MINMAX_EN
    logic [DATA_W-1:0] min;
    logic [DATA_W-1:0] max;
`endif
  } result_t;

endpackage

// File: rtl/adc_avg_if.sv
// Sample-in / result-out bus of the adc_avg averager; slave is the averager side.
// The min/max signals exist only when ADC_AVG_MINMAX_EN is defined.
interface adc_avg_if;
  import adc_avg_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic [CHAN_W-1:0] in_channel;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic [CHAN_W-1:0] out_channel;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;
`ifdef ADC_AVG_MINMAX_EN
  logic [DATA_W-1:0] out_min;
  logic [DATA_W-1:0] out_max;
`endif

  modport master (
    output in_data, in_channel, in_valid, out_ready,
    input  out_data, out_channel, out_valid, overrun
`ifdef ADC_AVG_MINMAX_EN
    , input out_min, out_max
`endif
  );

  modport slave (
    input  in_data, in_channel, in_valid, out_ready,
    output out_data, out_channel, out_valid, overrun
`ifdef ADC_AVG_MINMAX_EN
    , output out_min, out_max
`endif
  );

endinterface

// File: rtl/adc_avg_lane.sv
// One channel of the averager: window accumulator, sample count and optional
// min/max trackers (ADC_AVG_MINMAX_EN). Emits a combinational completion strobe.
module adc_avg_lane
  import adc_avg_pkg::*;
#(
  parameter int unsigned LOG2_AVG = 4,
  parameter int unsigned CHAN_ID  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              complete_c,
  output result_t           result_c
);

  localparam int unsigned ACC_W = acc_w(LOG2_AVG);
  // A zero-length count is kept one bit wide; it then stays at 0 and every sample completes
  localparam int unsigned CNT_W = (LOG2_AVG == 0) ? 1 : LOG2_AVG;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum_c;

  assign sum_c      = acc + ACC_W'(sample);
  assign complete_c = sample_valid & (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_valid) begin
      if (cnt == CNT_LAST) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum_c;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef ADC_AVG_MINMAX_EN
  logic [DATA_W-1:0] min_q;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] win_min_c;
  logic [DATA_W-1:0] win_max_c;

  assign win_min_c = (sample < min_q) ? sample : min_q;
  assign win_max_c = (sample > max_q) ? sample : max_q;

  // Trackers restart at the window boundary so the next window starts clean
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= '1;
      max_q <= '0;
    end else if (clear) begin
      min_q <= '1;
      max_q <= '0;
    end else if (sample_valid) begin
      if (cnt == CNT_LAST) begin
        min_q <= '1;
        max_q <= '0;
      end else begin
        min_q <= win_min_c;
        max_q <= win_max_c;
      end
    end
  end
`endif

  always_comb begin
    result_c         = '0;
    result_c.data    = DATA_W'(sum_c >> LOG2_AVG);
    result_c.channel = CHAN_W'(CHAN_ID);
`ifdef ADC_AVG_MINMAX_EN
    result_c.min     = win_min_c;
    result_c.max     = win_max_c;
`endif
  end

endmodule

// File: rtl/adc_avg.sv
// Per-channel boxcar averager/decimator with a valid/ready result hold register.
// Define ADC_AVG_MINMAX_EN to also report the window's raw min/max samples.
module adc_avg
  import adc_avg_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 8,
  parameter int unsigned LOG2_AVG = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  adc_avg_if.slave   bus
);

  logic    [NUM_CHAN-1:0] lane_valid;
  logic    [NUM_CHAN-1:0] lane_done;
  result_t                lane_res [NUM_CHAN];

  logic    hit_c;
  result_t res_c;

  result_t out_q;
  logic    out_valid;
  logic    overrun;

  // Tags at or above NUM_CHAN match no lane and are dropped; clear discards the sample
  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_lane
    assign lane_valid[i] = bus.in_valid & ~clear & (bus.in_channel == CHAN_W'(i));

    adc_avg_lane #(
      .LOG2_AVG (LOG2_AVG),
      .CHAN_ID  (i)
    ) u_lane (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (clear),
      .sample_valid (lane_valid[i]),
      .sample       (bus.in_data),
      .complete_c   (lane_done[i]),
      .result_c     (lane_res[i])
    );
  end

  // Only the addressed lane can complete in a cycle, so a plain select suffices
  always_comb begin
    hit_c = 1'b0;
    res_c = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (lane_done[i]) begin
        hit_c = 1'b1;
        res_c = lane_res[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (hit_c && (!out_valid || bus.out_ready)) begin
      out_q     <= res_c;
      out_valid <= 1'b1;
    end else if (hit_c) begin
      overrun   <= 1'b1;
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_data    = out_q.data;
  assign bus.out_channel = out_q.channel;
  assign bus.out_valid   = out_valid;
  assign bus.overrun     = overrun;
`ifdef ADC_AVG_MINMAX_EN
  assign bus.out_min     = out_q.min;
  assign bus.out_max     = out_q.max;
`endif

endmodule
